// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the decode-stage control path with the CNN extension.
// Holds the opcode values, the ImmSrc/ResultSrc/ALUOp encodings, the MAC
// sequencer state type and the ID/EX control bundle type.
package cnn_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_CNN    = 7'b0101011;

    localparam logic [2:0] F3_CNN_MAC = 3'b000;
    localparam logic [2:0] F3_CNN_ALU = 3'b001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] RES_ALU = 3'b000;
    localparam logic [2:0] RES_MEM = 3'b001;
    localparam logic [2:0] RES_PC4 = 3'b010;
    localparam logic [2:0] RES_IMM = 3'b011;
    localparam logic [2:0] RES_ACC = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_CNN   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [2:0] result_src;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic       ctrl_valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Bundle presented for the single writeback cycle of a MAC result.
    function automatic ctrl_t wb_ctrl();
        ctrl_t c;
        c            = CTRL_BUBBLE;
        c.reg_write  = 1'b1;
        c.result_src = RES_ACC;
        c.alu_op     = ALU_CNN;
        c.ctrl_valid = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/main_decoder_seq_if.sv
// Decode/accelerator bus of main_decoder_seq.
// slave  : the decoder (takes instruction fields and accelerator status,
//          drives the control bundle, stall and accelerator request).
// master : the surrounding pipeline / accelerator model.
interface main_decoder_seq_if #(
    parameter int unsigned ITER_W = 8
);
    logic              instr_valid;
    logic [6:0]        Op;
    logic [2:0]        funct3;
    logic [ITER_W-1:0] iter_cnt;
    logic              stall_in;
    logic              flush;
    logic              acc_ready;
    logic              acc_done;

    logic              RegWrite;
    logic [2:0]        ImmSrc;
    logic              ALUSrc;
    logic              MemWrite;
    logic [2:0]        ResultSrc;
    logic              Branch;
    logic              Jump;
    logic [1:0]        ALUOp;
    logic              ctrl_valid;
    logic              illegal;
    logic              stall_out;
    logic              acc_start;
    logic [ITER_W-1:0] acc_len;
    logic              acc_abort;
    logic              err;

    modport master (
        output instr_valid, Op, funct3, iter_cnt, stall_in, flush, acc_ready, acc_done,
        input  RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp,
               ctrl_valid, illegal, stall_out, acc_start, acc_len, acc_abort, err
    );

    modport slave (
        input  instr_valid, Op, funct3, iter_cnt, stall_in, flush, acc_ready, acc_done,
        output RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp,
               ctrl_valid, illegal, stall_out, acc_start, acc_len, acc_abort, err
    );
endinterface

// File: rtl/main_decoder_comb.sv
// Pure combinational Op/funct3 -> control table.
// Ports:
//   i_op      opcode [6:0]
//   i_funct3  funct3, only meaningful for the CNN opcode
//   o_ctrl    control bundle (ctrl_valid=1 for every legal single-cycle op)
//   o_illegal unknown opcode or unsupported CNN funct3
//   o_mac     CNN MAC-mode instruction (bundle is a bubble; sequenced elsewhere)
module main_decoder_comb
    import cnn_ctrl_pkg::*;
#(
    parameter logic [6:0] CNN_OPCODE = OP_CNN
) (
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    output ctrl_t      o_ctrl,
    output logic       o_illegal,
    output logic       o_mac
);

    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_illegal = 1'b0;
        o_mac     = 1'b0;
        case (i_op)
            OP_LOAD: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.imm_src    = IMM_I;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.result_src = RES_MEM;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.ctrl_valid = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.imm_src    = IMM_S;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.ctrl_valid = 1'b1;
            end
            OP_RTYPE: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_ALU;
                o_ctrl.alu_op     = ALU_FUNCT;
                o_ctrl.ctrl_valid = 1'b1;
            end
            OP_IALU: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.imm_src    = IMM_I;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.alu_op     = ALU_FUNCT;
                o_ctrl.ctrl_valid = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.imm_src    = IMM_B;
                o_ctrl.branch     = 1'b1;
                o_ctrl.alu_op     = ALU_SUB;
                o_ctrl.ctrl_valid = 1'b1;
            end
            OP_JAL: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.imm_src    = IMM_J;
                o_ctrl.jump       = 1'b1;
                o_ctrl.result_src = RES_PC4;
                o_ctrl.ctrl_valid = 1'b1;
            end
            OP_LUI: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.imm_src    = IMM_U;
                o_ctrl.result_src = RES_IMM;
                o_ctrl.ctrl_valid = 1'b1;
            end
            CNN_OPCODE: begin
                if (i_funct3 == F3_CNN_ALU) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.alu_op     = ALU_CNN;
                    o_ctrl.ctrl_valid = 1'b1;
                end else if (i_funct3 == F3_CNN_MAC) begin
                    o_mac = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/main_decoder_seq.sv
// Registered main control decoder with the CNN MAC handshake sequencer.
// Ports:
//   clk  core clock
//   rst  synchronous reset, active-high
//   bus  main_decoder_seq_if.slave:
//        in : instr_valid, Op, funct3, iter_cnt, stall_in, flush, acc_ready, acc_done
//        out: ID/EX control bundle (RegWrite..ALUOp, ctrl_valid), illegal,
//             stall_out (combinational), acc_start, acc_len, acc_abort, err
// Decoded controls load only while the sequencer is IDLE and stall_in is low.
// A MAC instruction issues a bubble, raises acc_start until acc_ready, then
// waits in BUSY for acc_done (bounded by TIMEOUT) and finishes with one
// writeback cycle selecting the accelerator result.
module main_decoder_seq
    import cnn_ctrl_pkg::*;
#(
    parameter logic [6:0]  CNN_OPCODE = OP_CNN,
    parameter int unsigned ITER_W     = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic              clk,
    input logic              rst,
    main_decoder_seq_if.slave bus
);

    localparam logic [ITER_W-1:0] TIMEOUT_CNT = ITER_W'(TIMEOUT);
    localparam logic [ITER_W-1:0] CNT_MAX     = '1;
    localparam logic [ITER_W-1:0] CNT_ONE     = ITER_W'(1);

    ctrl_t             w_dec_ctrl;
    logic              w_dec_illegal;
    logic              w_dec_mac;
    logic              w_mac_accept;

    state_t            r_state;
    ctrl_t             r_ctrl;
    logic              r_illegal;
    logic              r_acc_start;
    logic              r_acc_abort;
    logic              r_err;
    logic [ITER_W-1:0] r_acc_len;
    logic [ITER_W-1:0] r_busy_cnt;

    main_decoder_comb #(
        .CNN_OPCODE(CNN_OPCODE)
    ) u_dec (
        .i_op      (bus.Op),
        .i_funct3  (bus.funct3),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_mac     (w_dec_mac)
    );

    // The accepting IDLE cycle must already hold fetch so the MAC instruction
    // stays in decode for the whole sequence.
    assign w_mac_accept = !rst && !bus.flush && (r_state == IDLE) &&
                          bus.instr_valid && !bus.stall_in && w_dec_mac;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ctrl      <= CTRL_BUBBLE;
            r_illegal   <= 1'b0;
            r_acc_start <= 1'b0;
            r_acc_abort <= 1'b0;
            r_err       <= 1'b0;
            r_acc_len   <= '0;
            r_busy_cnt  <= '0;
        end else begin
            r_acc_abort <= 1'b0;
            if (bus.flush) begin
                r_state     <= IDLE;
                r_ctrl      <= CTRL_BUBBLE;
                r_illegal   <= 1'b0;
                r_acc_start <= 1'b0;
                r_busy_cnt  <= '0;
                r_acc_abort <= (r_state == REQ) || (r_state == BUSY);
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!bus.stall_in) begin
                            r_illegal <= 1'b0;
                            if (!bus.instr_valid) begin
                                r_ctrl <= CTRL_BUBBLE;
                            end else if (w_dec_mac) begin
                                r_ctrl      <= CTRL_BUBBLE;
                                r_acc_len   <= (bus.iter_cnt == '0) ? CNT_ONE : bus.iter_cnt;
                                r_acc_start <= 1'b1;
                                r_state     <= REQ;
                            end else begin
                                r_ctrl    <= w_dec_ctrl;
                                r_illegal <= w_dec_illegal;
                            end
                        end
                    end
                    REQ: begin
                        r_ctrl    <= CTRL_BUBBLE;
                        r_illegal <= 1'b0;
                        // acc_done is not looked at here, even alongside acc_ready.
                        if (bus.acc_ready) begin
                            r_acc_start <= 1'b0;
                            r_busy_cnt  <= '0;
                            r_state     <= BUSY;
                        end
                    end
                    BUSY: begin
                        r_ctrl    <= CTRL_BUBBLE;
                        r_illegal <= 1'b0;
                        if (bus.acc_done) begin
                            r_ctrl  <= wb_ctrl();
                            r_state <= WB;
                        end else if (r_busy_cnt == TIMEOUT_CNT) begin
                            r_acc_abort <= 1'b1;
                            r_err       <= 1'b1;
                            r_busy_cnt  <= '0;
                            r_state     <= IDLE;
                        end else if (r_busy_cnt != CNT_MAX) begin
                            r_busy_cnt <= r_busy_cnt + CNT_ONE;
                        end
                    end
                    WB: begin
                        r_ctrl    <= CTRL_BUBBLE;
                        r_illegal <= 1'b0;
                        r_state   <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.RegWrite   = r_ctrl.reg_write;
    assign bus.ImmSrc     = r_ctrl.imm_src;
    assign bus.ALUSrc     = r_ctrl.alu_src;
    assign bus.MemWrite   = r_ctrl.mem_write;
    assign bus.ResultSrc  = r_ctrl.result_src;
    assign bus.Branch     = r_ctrl.branch;
    assign bus.Jump       = r_ctrl.jump;
    assign bus.ALUOp      = r_ctrl.alu_op;
    assign bus.ctrl_valid = r_ctrl.ctrl_valid;
    assign bus.illegal    = r_illegal;
    assign bus.acc_start  = r_acc_start;
    assign bus.acc_len    = r_acc_len;
    assign bus.acc_abort  = r_acc_abort;
    assign bus.err        = r_err;
    assign bus.stall_out  = !rst && ((r_state == REQ) || (r_state == BUSY) || w_mac_accept);

endmodule

// File: tb/tb_main_decoder_seq.sv
module tb_main_decoder_seq;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    main_decoder_seq_if #(.ITER_W(8)) bus ();

    main_decoder_seq #(
        .CNN_OPCODE(7'b0101011),
        .ITER_W    (8),
        .TIMEOUT   (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        stall;
        logic        fl;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[15];

    // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp, ctrl_valid, illegal}
    function automatic logic [14:0] obs();
        return {bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.MemWrite, bus.ResultSrc,
                bus.Branch, bus.Jump, bus.ALUOp, bus.ctrl_valid, bus.illegal};
    endfunction

    function automatic logic [26:0] all_out();
        return {obs(), bus.stall_out, bus.acc_start, bus.acc_abort, bus.err, bus.acc_len};
    endfunction

    function automatic vec_t mk(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                input logic st, input logic fl,
                                input logic rw, input logic [2:0] imm, input logic as,
                                input logic mw, input logic [2:0] rs, input logic br,
                                input logic j, input logic [1:0] ao, input logic cv,
                                input logic il);
        vec_t r;
        r.valid = v;
        r.op    = op;
        r.f3    = f3;
        r.stall = st;
        r.fl    = fl;
        r.exp   = {rw, imm, as, mw, rs, br, j, ao, cv, il};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [7:0] it);
        bus.instr_valid = v;
        bus.Op          = op;
        bus.funct3      = f3;
        bus.iter_cnt    = it;
    endtask

    localparam logic [6:0]  CNN     = 7'b0101011;
    localparam logic [6:0]  RTYPE   = 7'b0110011;
    localparam logic [14:0] EXP_R   = {1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
    localparam logic [14:0] EXP_WB  = {1'b1, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic stall_ok;
        logic got;
        int   n;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        set_in(1'b1, RTYPE, 3'b000, 8'd0);
        bus.stall_in  = 1'b0;
        bus.flush     = 1'b0;
        bus.acc_ready = 1'b0;
        bus.acc_done  = 1'b0;

        // Reset with R-type presented: everything stays 0
        tick();
        chk("reset_c1", 32'(all_out()), 32'd0);
        tick();
        chk("reset_c2", 32'(all_out()), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_reset_rtype", 32'(obs()), 32'(EXP_R));

        //            v     op          f3      st    fl    rw    imm     as    mw    rs      br    j     ao     cv    il
        vecs[0]  = mk(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        vecs[1]  = mk(1'b1, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        vecs[2]  = mk(1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 7'b0010011, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 7'b0101011, 3'b001, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 7'b0000011, 3'b000, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 7'b0101011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        vecs[12] = mk(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        vecs[13] = mk(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        vecs[14] = mk(1'b1, 7'b0101011, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].valid, vecs[i].op, vecs[i].f3, 8'd0);
            bus.stall_in = vecs[i].stall;
            bus.flush    = vecs[i].fl;
            tick();
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_stall_out", i), 32'(bus.stall_out), 32'd0);
        end
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;

        // MAC, iter_cnt=0, ready after 2 REQ cycles, done 5 cycles later
        set_in(1'b1, CNN, 3'b000, 8'd0);
        #1;
        chk("mac_accept_stall", 32'(bus.stall_out), 32'd1);
        tick();
        chk("mac_req_start", 32'(bus.acc_start), 32'd1);
        chk("mac_len_min1", 32'(bus.acc_len), 32'd1);
        chk("mac_req_bubble_stall", 32'({bus.ctrl_valid, bus.stall_out}), 32'b01);
        tick();
        chk("mac_req_hold", 32'(bus.acc_start), 32'd1);
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        chk("mac_busy_start_low", 32'({bus.acc_start, bus.stall_out}), 32'b01);
        stall_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (!bus.stall_out || bus.ctrl_valid) stall_ok = 1'b0;
        end
        chk("mac_busy_stalled", 32'(stall_ok), 32'd1);
        bus.acc_done = 1'b1;
        tick();
        bus.acc_done = 1'b0;
        chk("mac_wb_bundle", 32'(obs()), 32'(EXP_WB));
        chk("mac_wb_stall_low", 32'(bus.stall_out), 32'd0);
        tick();
        chk("mac_after_wb_bubble", 32'(obs()), 32'd0);
        set_in(1'b1, RTYPE, 3'b000, 8'd0);
        tick();
        chk("mac_next_rtype", 32'(obs()), 32'(EXP_R));

        // done ignored in REQ; ready+done together only moves to BUSY
        set_in(1'b1, CNN, 3'b000, 8'd200);
        tick();
        chk("rd_len200", 32'(bus.acc_len), 32'd200);
        bus.acc_done = 1'b1;
        tick();
        chk("rd_done_in_req", 32'({bus.acc_start, bus.ctrl_valid}), 32'b10);
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        bus.acc_done  = 1'b0;
        chk("rd_both_busy", 32'({bus.acc_start, bus.stall_out, bus.ctrl_valid}), 32'b010);
        tick();
        chk("rd_still_busy", 32'({bus.stall_out, bus.ctrl_valid}), 32'b10);
        bus.acc_done = 1'b1;
        tick();
        bus.acc_done = 1'b0;
        chk("rd_wb", 32'(obs()), 32'(EXP_WB));
        tick();
        set_in(1'b0, RTYPE, 3'b000, 8'd0);
        tick();

        // Timeout: acc_done never arrives
        set_in(1'b1, CNN, 3'b000, 8'd5);
        tick();
        chk("to_len", 32'(bus.acc_len), 32'd5);
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        got = 1'b0;
        n = 0;
        stall_ok = 1'b1;
        for (int k = 1; k <= 400 && !got; k++) begin
            tick();
            if (bus.acc_abort) begin
                got = 1'b1;
                n = k;
            end else if (!bus.stall_out || bus.err) begin
                stall_ok = 1'b0;
            end
        end
        chk("to_abort_seen", 32'(got), 32'd1);
        chk("to_busy_window", 32'((n == 255) || (n == 256)), 32'd1);
        chk("to_stall_before_abort", 32'(stall_ok), 32'd1);
        set_in(1'b0, RTYPE, 3'b000, 8'd0);
        #1;
        chk("to_err_stall_cv", 32'({bus.err, bus.stall_out, bus.ctrl_valid}), 32'b100);
        tick();
        chk("to_abort_pulse_err", 32'({bus.acc_abort, bus.err}), 32'b01);

        // flush in BUSY, acc_done the following cycle
        set_in(1'b1, CNN, 3'b000, 8'd3);
        tick();
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.acc_done = 1'b1;
        set_in(1'b1, RTYPE, 3'b000, 8'd0);
        #1;
        chk("fl_abort_pulse", 32'({bus.acc_abort, bus.ctrl_valid, bus.stall_out, bus.err}), 32'b1001);
        tick();
        bus.acc_done = 1'b0;
        chk("fl_no_wb_next_rtype", 32'(obs()), 32'(EXP_R));
        chk("fl_abort_cleared", 32'(bus.acc_abort), 32'd0);

        // flush in REQ
        set_in(1'b1, CNN, 3'b000, 8'd7);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        set_in(1'b0, RTYPE, 3'b000, 8'd0);
        #1;
        chk("flreq_abort", 32'({bus.acc_abort, bus.acc_start, bus.stall_out}), 32'b100);

        // reset mid-MAC
        set_in(1'b1, CNN, 3'b000, 8'd9);
        tick();
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_mid_mac", 32'(all_out()), 32'd0);
        rst = 1'b0;
        set_in(1'b1, 7'b1101111, 3'b000, 8'd0);
        tick();
        chk("rst_then_jal", 32'(obs()),
            32'({1'b1, 3'b011, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
